// File: rtl/digest_tail_merge_pkg.sv
// Shared types for digest_tail_merge: FSM states, per-packet tail mode and
// sticky error bit positions.
package digest_tail_pkg;

  typedef enum logic {
    PASS = 1'b0,
    DIG  = 1'b1
  } state_e;

  typedef enum logic {
    MODE_REPLACE = 1'b0,
    MODE_APPEND  = 1'b1
  } mode_e;

  localparam int ERR_OVERLEN    = 0;
  localparam int ERR_IDMISMATCH = 1;

endpackage

// File: rtl/digest_tail_merge_axis_out_reg.sv
// Single-entry registered output slice. The slot is free when empty or when
// the held beat is being taken this cycle; the parent only loads a free slot.
module axis_out_reg #(
  parameter  int DATA_W = 512,
  parameter  int ID_W   = 6,
  localparam int KEEP_W = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic [ID_W-1:0]   id_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              slot_free_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [KEEP_W-1:0] keep_o,
  output logic [ID_W-1:0]   id_o,
  output logic              last_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [KEEP_W-1:0] keep_q;
  logic [ID_W-1:0]   id_q;
  logic              last_q;

  assign slot_free_o = !valid_q || ready_i;

  // NOTE: state is written with non-blocking assignments only, so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      id_q    <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      keep_q  <= keep_i;
      id_q    <= id_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign id_o    = id_q;
  assign last_o  = last_q;

endmodule

// File: rtl/digest_tail_merge.sv
// Merges a payload stream with a per-packet digest stream, replacing or
// following the last payload beat. Define TAIL_ID_CHECK_EN to flag digest ID mismatches.
module digest_tail_merge
  import digest_tail_pkg::*;
#(
  parameter  int DATA_W        = 512,
  parameter  int ID_W          = 6,
  parameter  int MAX_DIG_BEATS = 2,
  parameter  int CNT_W         = 32,
  localparam int KEEP_W        = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode,
  input  logic              inp_valid,
  output logic              inp_ready,
  input  logic [DATA_W-1:0] inp_data,
  input  logic [KEEP_W-1:0] inp_keep,
  input  logic [ID_W-1:0]   inp_id,
  input  logic              inp_last,
  input  logic              chk_valid,
  output logic              chk_ready,
  input  logic [DATA_W-1:0] chk_data,
  input  logic [KEEP_W-1:0] chk_keep,
  input  logic [ID_W-1:0]   chk_id,
  input  logic              chk_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic [ID_W-1:0]   out_id,
  output logic              out_last,
  output logic [1:0]        err,
  output logic [CNT_W-1:0]  pkt_count
);

  localparam int BCW = (MAX_DIG_BEATS > 1) ? $clog2(MAX_DIG_BEATS) : 1;

  state_e            state_q;
  logic              first_q;
  mode_e             mode_q;
  logic [ID_W-1:0]   id_q;
  logic [BCW-1:0]    cnt_q;
  logic [1:0]        err_q;
  logic [CNT_W-1:0]  pkt_count_q;

  logic              slot_free;
  logic              inp_acc, chk_acc, dig_end, id_err;
  mode_e             cur_mode;
  logic              ld, ld_last;
  logic [DATA_W-1:0] ld_data;
  logic [KEEP_W-1:0] ld_keep;
  logic [ID_W-1:0]   ld_id;

  assign inp_ready = !reset && (state_q == PASS) && slot_free;
  assign chk_ready = !reset && (state_q == DIG) && slot_free;
  assign inp_acc   = inp_valid && inp_ready;
  assign chk_acc   = chk_valid && chk_ready;
  assign cur_mode  = first_q ? mode_e'(mode) : mode_q;
  // A digest also ends when the beat budget runs out, whatever chk_last says.
  assign dig_end   = chk_last || (cnt_q == BCW'(MAX_DIG_BEATS - 1));

`ifdef TAIL_ID_CHECK_EN
  assign id_err = chk_acc && (cnt_q == '0) && (chk_id != id_q);
`else
  logic unused_chk_id;
  assign unused_chk_id = ^chk_id;
  assign id_err        = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    ld      = 1'b0;
    ld_data = inp_data;
    ld_keep = inp_keep;
    ld_id   = inp_id;
    ld_last = 1'b0;
    if (inp_acc) begin
      ld = !(inp_last && (cur_mode == MODE_REPLACE));
    end else if (chk_acc) begin
      ld      = 1'b1;
      ld_data = chk_data;
      ld_keep = chk_keep;
      ld_id   = id_q;
      ld_last = dig_end;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= PASS;
      first_q     <= 1'b1;
      mode_q      <= MODE_REPLACE;
      id_q        <= '0;
      cnt_q       <= '0;
      err_q       <= '0;
      pkt_count_q <= '0;
    end else begin
      if (inp_acc) begin
        if (first_q) begin
          mode_q <= mode_e'(mode);
          id_q   <= inp_id;
        end
        first_q <= 1'b0;
        if (inp_last) state_q <= DIG;
      end
      if (chk_acc) begin
        if (dig_end) begin
          cnt_q       <= '0;
          first_q     <= 1'b1;
          state_q     <= PASS;
          pkt_count_q <= pkt_count_q + CNT_W'(1);
          if (!chk_last) err_q[ERR_OVERLEN] <= 1'b1;
        end else begin
          cnt_q <= cnt_q + BCW'(1);
        end
        if (id_err) err_q[ERR_IDMISMATCH] <= 1'b1;
      end
    end
  end

  assign err       = err_q;
  assign pkt_count = pkt_count_q;

  axis_out_reg #(
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) u_out_reg (
    .clock       (clock),
    .reset       (reset),
    .load_i      (ld),
    .data_i      (ld_data),
    .keep_i      (ld_keep),
    .id_i        (ld_id),
    .last_i      (ld_last),
    .ready_i     (out_ready),
    .slot_free_o (slot_free),
    .valid_o     (out_valid),
    .data_o      (out_data),
    .keep_o      (out_keep),
    .id_o        (out_id),
    .last_o      (out_last)
  );

endmodule
